flex_counter_ext: RTL

Parametrised multi-mode counter for the USB receive path. It extends the basic flexible counter with:
- up/down counting and a synchronous load;
- four wrap modes: legacy wrap-to-1, wrap-to-0, saturate, one-shot;
- an enable prescaler;
- a one-cycle terminal pulse.

Bit-period timers, byte/bit counters and timeout watchdogs in `rx` instantiate it, each with its own width.

---
 rtl/flex_counter_pkg.sv | 29 ++
 rtl/flex_counter_ext_prescaler.sv | 32 +++
 rtl/flex_counter_ext.sv | 97 +++++++++
 3 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types and helpers for the flexible counter family.
package flex_counter_pkg;

    // Widest counter any instance may use; terminal_val works at this width.
    localparam int MAX_CNT_BITS = 32;

    typedef enum logic [1:0] {
        WRAP1   = 2'b00,
        WRAP0   = 2'b01,
        SAT     = 2'b10,
        ONESHOT = 2'b11
    } cnt_mode_t;

    // Value at which the counter raises its flag for the given mode and direction.
    function automatic logic [MAX_CNT_BITS-1:0] terminal_val(
        input cnt_mode_t               mode,
        input logic                    dir,
        input logic [MAX_CNT_BITS-1:0] rollover_val
    );
        if (dir) begin
            return rollover_val;
        end else if (mode == WRAP1) begin
            return MAX_CNT_BITS'(1);
        end else begin
            return '0;
        end
    endfunction

endpackage

// File: rtl/flex_counter_ext_prescaler.sv
// Enable prescaler: tick marks every (div_val+1)-th enabled cycle.
module prescaler #(
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     sync_clr,
    input  logic                     enable,
    input  logic [PRESCALE_BITS-1:0] div_val,
    output logic                     tick
);

    logic [PRESCALE_BITS-1:0] pre_cnt;

    assign tick = (pre_cnt == div_val);

    // Advance on enabled cycles, return to zero on tick or synchronous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pre_cnt <= '0;
        end else if (sync_clr) begin
            pre_cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/flex_counter_ext.sv
// Multi-mode up/down counter with load, prescaler, wrap modes and terminal pulse.
module flex_counter_ext
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS  = 4,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     count_enable,
    input  logic                     count_up,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic [1:0]               mode,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    input  logic [PRESCALE_BITS-1:0] prescale_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     rollover_pulse,
    output logic                     done
);

    cnt_mode_t               mode_e;
    logic                    tick;
    logic                    step;
    logic                    at_term;
    logic                    hold_at_term;
    logic [NUM_CNT_BITS-1:0] term;
    logic [NUM_CNT_BITS-1:0] next_cnt;

    assign mode_e = cnt_mode_t'(mode);

    prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_prescaler (
        .clk     (clk),
        .n_rst   (n_rst),
        .sync_clr(clear | load),
        .enable  (count_enable),
        .div_val (prescale_val),
        .tick    (tick)
    );

    // Terminal compare and the value the next step would produce.
    always_comb begin
        term         = NUM_CNT_BITS'(terminal_val(mode_e, count_up, MAX_CNT_BITS'(rollover_val)));
        at_term      = (count_out == term);
        hold_at_term = (mode_e == SAT) || (mode_e == ONESHOT);
        next_cnt     = count_out;
        if (at_term) begin
            if (hold_at_term) begin
                next_cnt = count_out;
            end else if (count_up) begin
                next_cnt = (mode_e == WRAP1) ? NUM_CNT_BITS'(1) : '0;
            end else begin
                next_cnt = rollover_val;
            end
        end else if (count_up) begin
            next_cnt = count_out + NUM_CNT_BITS'(1);
        end else begin
            next_cnt = count_out - NUM_CNT_BITS'(1);
        end
        // A completed one-shot ignores steps until cleared or reloaded.
        step = count_enable && tick && !done;
    end

    // Output registers: clear beats load beats step; pulse self-clears.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
            done           <= 1'b0;
        end else if (clear) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
            done           <= 1'b0;
        end else if (load) begin
            count_out      <= load_val;
            rollover_flag  <= (load_val == term);
            rollover_pulse <= 1'b0;
            done           <= 1'b0;
        end else if (step) begin
            count_out      <= next_cnt;
            rollover_flag  <= (next_cnt == term);
            rollover_pulse <= (next_cnt == term) && (next_cnt != count_out);
            if ((mode_e == ONESHOT) && (next_cnt == term)) begin
                done <= 1'b1;
            end
        end else begin
            rollover_pulse <= 1'b0;
        end
    end

endmodule
